// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared widths, opcode field and fetch state encoding for the
//             instruction fetch path.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int MEM_DEPTH  = 256;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 6'b111111;

   typedef enum logic [0:0] {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Brief    : Program counter with increment, wrap mask and redirect mux.
//             The PC is kept inside the memory's address range, so its upper
//             bits are always zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_reg #(
   parameter int                ADDR_W    = 16,
   parameter int                MEM_DEPTH = 256,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              advance,
   output logic [ADDR_W-1:0] pc
);

   // MEM_DEPTH is a power of two, so depth-1 is the wrap mask
   localparam logic [ADDR_W-1:0] C_PC_MASK = ADDR_W'(MEM_DEPTH - 1);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_inc;

   assign w_pc_inc = (r_pc + ADDR_W'(1)) & C_PC_MASK;
   assign pc       = r_pc;

   // PC update: redirect beats sequential advance; otherwise hold
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC & C_PC_MASK;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc & C_PC_MASK;
      end else if (advance) begin
         r_pc <= w_pc_inc;
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Brief    : Instruction fetch master. Drives the memory address from the PC,
//             captures each word into the IR and hands it to decode over a
//             valid/ready handshake. Supports redirect and stops on HALT.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
   parameter int                ADDR_W      = cpu_pkg::ADDR_W,
   parameter int                DATA_W      = cpu_pkg::DATA_W,
   parameter int                MEM_DEPTH   = cpu_pkg::MEM_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [5:0]        HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   import cpu_pkg::*;

   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [ADDR_W-1:0] w_pc;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_ir_pc;
   logic              r_ir_valid;
   logic [15:0]       r_fetch_count;
   logic              w_accept;
   logic              w_load;
   logic              w_is_halt;
   logic              w_advance;

   assign w_accept  = r_ir_valid & ir_ready;
   assign w_load    = (r_state == FETCH) & (~r_ir_valid | ir_ready) & ~redirect_valid;
   assign w_is_halt = (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
   // the HALT word is captured but the PC stays on it
   assign w_advance = w_load & ~w_is_halt;

   pc_reg #(
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH),
      .RESET_PC  (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (w_advance),
      .pc             (w_pc)
   );

   // Fetch state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: redirect always resumes fetching, a loaded HALT word stops it
   always_comb begin
      w_state_next = r_state;
      if (redirect_valid) begin
         w_state_next = FETCH;
      end else if (w_load && w_is_halt) begin
         w_state_next = HALTED;
      end
   end

   // Instruction register and its valid flag; redirect discards any pending IR
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else if (redirect_valid) begin
         r_ir_valid <= 1'b0;
      end else if (w_load) begin
         r_ir       <= imem_data;
         r_ir_pc    <= w_pc;
         r_ir_valid <= 1'b1;
      end else if (w_accept) begin
         r_ir_valid <= 1'b0;
      end
   end

   // Delivered-instruction counter; counts handshakes even in a redirect cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_count <= '0;
      end else if (w_accept) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign imem_addr   = w_pc;
   assign ir          = r_ir;
   assign ir_pc       = r_ir_pc;
   assign ir_valid    = r_ir_valid;
   assign halted      = (r_state == HALTED);
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Brief    : Self-checking bench for inst_fetch_unit: directed vector table,
//             reset corner cases, then randomized traffic against a
//             behavioural model of the fetch rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [15:0] ir_pc;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [0:255];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[7:0]];

   inst_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .ir             (ir),
      .ir_pc          (ir_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [15:0] rpc;
      logic        v;
      logic [31:0] ir;
      logic [15:0] ipc;
      logic [15:0] addr;
      logic [15:0] cnt;
      logic        h;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic rdy, input logic rv, input logic [15:0] rpc,
                       input logic v, input logic [31:0] eir, input logic [15:0] ipc,
                       input logic [15:0] addr, input logic [15:0] cnt, input logic h);
      vec_t t;
      t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.v = v; t.ir = eir;
      t.ipc = ipc; t.addr = addr; t.cnt = cnt; t.h = h;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // behavioural model state
   int          m_pc;
   logic        m_v;
   logic [31:0] m_ir;
   int          m_irpc;
   logic        m_h;
   int          m_cnt;

   task automatic model_cycle(input logic rst, input logic rv, input logic [15:0] rpc,
                              input logic rdy);
      logic        delivered;
      logic [31:0] word;
      if (rst) begin
         m_pc = 0; m_v = 1'b0; m_ir = '0; m_irpc = 0; m_h = 1'b0; m_cnt = 0;
      end else begin
         delivered = m_v && rdy;
         if (delivered) m_cnt = (m_cnt + 1) % 65536;
         if (rv) begin
            m_pc = int'(rpc) % 256;
            m_v  = 1'b0;
            m_h  = 1'b0;
         end else if (!m_h && (!m_v || rdy)) begin
            word   = mem[m_pc];
            m_ir   = word;
            m_irpc = m_pc;
            m_v    = 1'b1;
            if (word[31:26] == 6'h3f) m_h = 1'b1;
            else m_pc = (m_pc + 1) % 256;
         end else if (delivered) begin
            m_v = 1'b0;
         end
      end
   endtask

   localparam logic [31:0] WA = 32'h6842000A;
   localparam logic [31:0] WB = 32'h6884000C;
   localparam logic [31:0] WC = 32'h40C22000;
   localparam logic [31:0] WH = 32'hFC000000;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0400_0000 | 32'(i);
      mem[0]    = WA;
      mem[1]    = WB;
      mem[2]    = WC;
      mem[3]    = WH;
      mem[8'h80] = 32'h2222_0080;
      mem[8'hFF] = 32'h1111_1111;

      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
      step;
      check("reset_valid", ir_valid, 0);
      check("reset_ir", ir, 0);
      check("reset_ir_pc", ir_pc, 0);
      check("reset_addr", imem_addr, 0);
      check("reset_halted", halted, 0);
      check("reset_count", fetch_count, 0);
      reset = 1'b0;

      // straight stream up to the HALT word
      addv(1, 0, 0,     1, WA, 0, 1, 0, 0);
      addv(1, 0, 0,     1, WB, 1, 2, 1, 0);
      addv(1, 0, 0,     1, WC, 2, 3, 2, 0);
      addv(1, 0, 0,     1, WH, 3, 3, 3, 1);
      addv(1, 0, 0,     0, WH, 3, 3, 4, 1);
      for (int i = 0; i < 10; i++) addv(1, 0, 0, 0, WH, 3, 3, 4, 1);
      // leave HALTED by redirect to 0, then backpressure on mem[1]
      addv(1, 1, 16'h0, 0, 0, 0, 0, 4, 0);
      addv(0, 0, 0,     1, WA, 0, 1, 4, 0);
      addv(1, 0, 0,     1, WB, 1, 2, 5, 0);
      addv(0, 0, 0,     1, WB, 1, 2, 5, 0);
      addv(0, 0, 0,     1, WB, 1, 2, 5, 0);
      addv(0, 0, 0,     1, WB, 1, 2, 5, 0);
      addv(1, 0, 0,     1, WC, 2, 3, 6, 0);
      // redirect while stalled: IR dropped, nothing counted
      addv(0, 1, 16'h0080, 0, 0, 0, 16'h80, 6, 0);
      addv(0, 0, 0,     1, 32'h2222_0080, 16'h80, 16'h81, 6, 0);
      // redirect with an accept in the same cycle, to the last word
      addv(1, 1, 16'h00FF, 0, 0, 0, 16'hFF, 7, 0);
      addv(1, 0, 0,     1, 32'h1111_1111, 16'hFF, 0, 7, 0);
      addv(1, 0, 0,     1, WA, 0, 1, 8, 0);
      // out-of-range redirect target is masked
      addv(0, 1, 16'h0105, 0, 0, 0, 5, 8, 0);
      addv(1, 0, 0,     1, 32'h0400_0005, 5, 6, 8, 0);

      foreach (vecs[k]) begin
         ir_ready       = vecs[k].rdy;
         redirect_valid = vecs[k].rv;
         redirect_pc    = vecs[k].rpc;
         step;
         check($sformatf("v%0d_valid", k), ir_valid, vecs[k].v);
         check($sformatf("v%0d_addr", k), imem_addr, vecs[k].addr);
         check($sformatf("v%0d_count", k), fetch_count, vecs[k].cnt);
         check($sformatf("v%0d_halted", k), halted, vecs[k].h);
         if (vecs[k].v) begin
            check($sformatf("v%0d_ir", k), ir, vecs[k].ir);
            check($sformatf("v%0d_ir_pc", k), ir_pc, vecs[k].ipc);
         end
      end

      // reset mid-stream, with a redirect in the same cycle that must lose
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040; ir_ready = 1'b0;
      step;
      check("midrst_valid", ir_valid, 0);
      check("midrst_ir", ir, 0);
      check("midrst_ir_pc", ir_pc, 0);
      check("midrst_addr", imem_addr, 0);
      check("midrst_count", fetch_count, 0);
      check("midrst_halted", halted, 0);
      reset = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b1;
      step;
      check("postrst_valid", ir_valid, 1);
      check("postrst_ir", ir, WA);
      check("postrst_addr", imem_addr, 1);

      // randomized traffic against the model, new memory image under reset
      reset = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = $urandom;
         if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
         if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3f;
         mem[i] = w;
      end
      for (int cyc = 0; cyc < 800; cyc++) begin
         int r;
         r              = $urandom_range(0, 99);
         reset          = (cyc == 0) || (r < 2);
         redirect_valid = (r >= 2) && (r < 12);
         redirect_pc    = 16'($urandom);
         ir_ready       = ($urandom_range(0, 2) != 0);
         model_cycle(reset, redirect_valid, redirect_pc, ir_ready);
         step;
         check("rnd_valid", ir_valid, m_v);
         check("rnd_addr", imem_addr, 64'(m_pc));
         check("rnd_count", fetch_count, 64'(m_cnt));
         check("rnd_halted", halted, m_h);
         if (m_v) begin
            check("rnd_ir", ir, m_ir);
            check("rnd_ir_pc", ir_pc, 64'(m_irpc));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
